// File: rtl/flag_controller.sv
// NZCV flag-write arbiter with one-entry exception shadow and a
// B.cond evaluator that waits out same-cycle flag writes.
module flag_controller #(
    parameter int STALL_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_req,
    input  logic [3:0]  alu_nzcv,
    output logic        alu_gnt,
    input  logic        sys_req,
    input  logic [3:0]  sys_nzcv,
    output logic        sys_gnt,
    input  logic        save_req,
    input  logic        restore_req,
    output logic        save_err,
    input  logic        cond_req,
    input  logic [3:0]  cond_code,
    output logic        cond_ack,
    output logic        cond_taken,
    output logic        busy,
    output logic [3:0]  nzcv,
    output logic [31:0] sreg
);
    localparam int CW = $clog2(STALL_LIMIT + 2);

    typedef enum logic [1:0] {
        IDLE,
        EVAL,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    nzcv_q, nzcv_d;
    logic [3:0]    shadow_q, shadow_d;
    logic          shadow_valid_q, shadow_valid_d;
    logic          save_err_q, save_err_d;
    logic          taken_q, taken_d;
    logic [3:0]    code_q, code_d;
    logic [CW-1:0] stall_q, stall_d;

    logic guard;
    logic block;
    logic rest_ok;
    logic wr;

    // Base condition on code[3:1]; code[0] inverts, except AL/NV.
    function automatic logic cond_eval(input logic [3:0] code,
                                       input logic [3:0] f);
        logic n, z, c, v, base;
        {n, z, c, v} = f;
        unique case (code[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (code[3:1] == 3'd7) begin
            return 1'b1;
        end
        return base ^ code[0];
    endfunction

    always_comb begin
        guard   = (state_q == EVAL) && (stall_q == CW'(STALL_LIMIT));
        block   = reset || guard;
        rest_ok = restore_req && shadow_valid_q && !block;
        sys_gnt = sys_req && !block && !rest_ok;
        alu_gnt = alu_req && !block && !rest_ok && !sys_req;
        wr      = rest_ok || sys_gnt || alu_gnt;
    end

    always_comb begin
        nzcv_d         = nzcv_q;
        shadow_d       = shadow_q;
        shadow_valid_d = shadow_valid_q;
        save_err_d     = save_err_q;
        if (rest_ok) begin
            nzcv_d = shadow_q;
        end else if (sys_gnt) begin
            nzcv_d = sys_nzcv;
        end else if (alu_gnt) begin
            nzcv_d = alu_nzcv;
        end
        // Restore wins over a same-cycle save; the save is dropped silently.
        if (restore_req) begin
            if (rest_ok) begin
                shadow_valid_d = 1'b0;
            end else if (!shadow_valid_q) begin
                save_err_d = 1'b1;
            end
        end else if (save_req) begin
            if (shadow_valid_q) begin
                save_err_d = 1'b1;
            end else begin
                shadow_d       = nzcv_q;
                shadow_valid_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        taken_d = taken_q;
        code_d  = code_q;
        stall_d = stall_q;
        unique case (state_q)
            IDLE: begin
                if (cond_req) begin
                    code_d  = cond_code;
                    stall_d = '0;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (wr) begin
                    stall_d = stall_q + 1'b1;
                end else begin
                    taken_d = cond_eval(code_q, nzcv_q);
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            nzcv_q         <= '0;
            shadow_q       <= '0;
            shadow_valid_q <= 1'b0;
            save_err_q     <= 1'b0;
            taken_q        <= 1'b0;
            code_q         <= '0;
            stall_q        <= '0;
        end else begin
            state_q        <= state_d;
            nzcv_q         <= nzcv_d;
            shadow_q       <= shadow_d;
            shadow_valid_q <= shadow_valid_d;
            save_err_q     <= save_err_d;
            taken_q        <= taken_d;
            code_q         <= code_d;
            stall_q        <= stall_d;
        end
    end

    assign cond_ack   = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign cond_taken = taken_q;
    assign save_err   = save_err_q;
    assign nzcv       = nzcv_q;
    assign sreg       = {nzcv_q, 28'b0};
endmodule

// File: tb/tb_flag_controller.sv
// Bench for flag_controller: directed scenarios plus randomized traffic
// checked against a cycle-level reference of the flag rules.
module tb_flag_controller;
    localparam int LIMIT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        alu_req = 1'b0;
    logic [3:0]  alu_nzcv = '0;
    logic        alu_gnt;
    logic        sys_req = 1'b0;
    logic [3:0]  sys_nzcv = '0;
    logic        sys_gnt;
    logic        save_req = 1'b0;
    logic        restore_req = 1'b0;
    logic        save_err;
    logic        cond_req = 1'b0;
    logic [3:0]  cond_code = '0;
    logic        cond_ack;
    logic        cond_taken;
    logic        busy;
    logic [3:0]  nzcv;
    logic [31:0] sreg;

    int n_cmp = 0;
    int n_bad = 0;

    flag_controller #(.STALL_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .alu_req(alu_req), .alu_nzcv(alu_nzcv), .alu_gnt(alu_gnt),
        .sys_req(sys_req), .sys_nzcv(sys_nzcv), .sys_gnt(sys_gnt),
        .save_req(save_req), .restore_req(restore_req),
        .save_err(save_err),
        .cond_req(cond_req), .cond_code(cond_code),
        .cond_ack(cond_ack), .cond_taken(cond_taken),
        .busy(busy), .nzcv(nzcv), .sreg(sreg)
    );

    always #5 clk = ~clk;

    // Reference state: committed flags, shadow, and the pending
    // evaluation described by its start cycle and resolved ack cycle.
    int       cyc = 0;
    logic [3:0] m_nzcv, m_shadow, m_code;
    logic     m_sv, m_err, m_taken, m_busy;
    int       m_start, m_ack_at;
    logic     e_rest, e_sys, e_alu;

    function automatic logic ref_cond(input logic [3:0] c,
                                      input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'b0000: return z;
            4'b0001: return !z;
            4'b0010: return cf;
            4'b0011: return !cf;
            4'b0100: return n;
            4'b0101: return !n;
            4'b0110: return v;
            4'b0111: return !v;
            4'b1000: return cf && !z;
            4'b1001: return !(cf && !z);
            4'b1010: return n == v;
            4'b1011: return n != v;
            4'b1100: return !z && (n == v);
            4'b1101: return !(!z && (n == v));
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        m_nzcv = '0; m_shadow = '0; m_code = '0;
        m_sv = 0; m_err = 0; m_taken = 0; m_busy = 0;
        m_start = 0; m_ack_at = -1;
    endtask

    task automatic model_comb();
        logic g;
        g = m_busy && m_ack_at < 0 && (cyc - m_start - 1) == LIMIT;
        g = g || reset;
        e_rest = restore_req && m_sv && !g;
        e_sys  = sys_req && !g && !e_rest;
        e_alu  = alu_req && !g && !e_rest && !e_sys;
    endtask

    task automatic tick();
        logic wr;
        logic [3:0] old;
        model_comb();
        wr = e_rest || e_sys || e_alu;
        old = m_nzcv;
        @(posedge clk);
        if (!reset) begin
            if (m_busy) begin
                if (m_ack_at == cyc) begin
                    m_busy = 0;
                    m_ack_at = -1;
                end else if (m_ack_at < 0 && !wr) begin
                    m_taken = ref_cond(m_code, old);
                    m_ack_at = cyc + 1;
                end
            end else if (cond_req) begin
                m_busy = 1;
                m_start = cyc;
                m_code = cond_code;
            end
            if (restore_req) begin
                if (e_rest) begin
                    m_nzcv = m_shadow;
                    m_sv = 0;
                end else if (!m_sv) begin
                    m_err = 1;
                end
            end else if (save_req) begin
                if (m_sv) m_err = 1;
                else begin
                    m_shadow = old;
                    m_sv = 1;
                end
            end
            if (e_sys) m_nzcv = sys_nzcv;
            else if (e_alu) m_nzcv = alu_nzcv;
        end
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        alu_req = 0; sys_req = 0; save_req = 0;
        restore_req = 0; cond_req = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        model_reset();
        tick();
        tick();
        reset = 0;
        #1;
    endtask

    task automatic set_flags(input logic [3:0] f);
        sys_req = 1; sys_nzcv = f;
        tick();
        sys_req = 0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        model_reset();
        alu_req = 1; sys_req = 1;
        #1;
        n_cmp++;
        if (alu_gnt !== 0 || sys_gnt !== 0) begin
            n_bad++;
            $display("FAIL reset_gnt alu=%b sys=%b want 0 0", alu_gnt, sys_gnt);
        end
        tick();
        n_cmp++;
        if ({nzcv, save_err, cond_ack, cond_taken, busy} !== 8'h0 ||
            sreg !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_state nzcv=%h err=%b ack=%b tk=%b busy=%b sreg=%h want 0",
                     nzcv, save_err, cond_ack, cond_taken, busy, sreg);
        end
        idle_inputs();
        tick();
        reset = 0;
        #1;
    endtask

    task automatic test_write();
        alu_req = 1; alu_nzcv = 4'b0110;
        #1;
        n_cmp++;
        if (alu_gnt !== 1) begin
            n_bad++;
            $display("FAIL write_gnt got %b want 1", alu_gnt);
        end
        tick();
        alu_req = 0;
        #1;
        n_cmp++;
        if (nzcv !== 4'b0110 || sreg !== 32'h6000_0000) begin
            n_bad++;
            $display("FAIL write_commit nzcv=%b sreg=%h want 0110 60000000",
                     nzcv, sreg);
        end
    endtask

    task automatic test_arb();
        sys_req = 1; sys_nzcv = 4'b1000;
        alu_req = 1; alu_nzcv = 4'b0001;
        #1;
        n_cmp++;
        if (sys_gnt !== 1 || alu_gnt !== 0) begin
            n_bad++;
            $display("FAIL arb_gnt sys=%b alu=%b want 1 0", sys_gnt, alu_gnt);
        end
        tick();
        sys_req = 0;
        #1;
        n_cmp++;
        if (nzcv !== 4'b1000 || alu_gnt !== 1) begin
            n_bad++;
            $display("FAIL arb_sys nzcv=%b alu_gnt=%b want 1000 1", nzcv, alu_gnt);
        end
        tick();
        alu_req = 0;
        #1;
        n_cmp++;
        if (nzcv !== 4'b0001) begin
            n_bad++;
            $display("FAIL arb_alu nzcv=%b want 0001", nzcv);
        end
    endtask

    task automatic test_eval();
        logic [3:0] codes [2];
        logic       want  [2];
        codes[0] = 4'b0000; want[0] = 1;
        codes[1] = 4'b1100; want[1] = 0;
        set_flags(4'b0100);
        for (int i = 0; i < 2; i++) begin
            cond_req = 1; cond_code = codes[i];
            tick();
            cond_req = 0;
            #1;
            n_cmp++;
            if (busy !== 1 || cond_ack !== 0 || (i == 1 && cond_taken !== 1)) begin
                n_bad++;
                $display("FAIL eval_t1_%0d busy=%b ack=%b tk=%b want 1 0 hold",
                         i, busy, cond_ack, cond_taken);
            end
            tick();
            n_cmp++;
            if (busy !== 1 || cond_ack !== 1 || cond_taken !== want[i]) begin
                n_bad++;
                $display("FAIL eval_t2_%0d busy=%b ack=%b tk=%b want 1 1 %b",
                         i, busy, cond_ack, cond_taken, want[i]);
            end
            tick();
            n_cmp++;
            if (busy !== 0 || cond_ack !== 0 || cond_taken !== want[i]) begin
                n_bad++;
                $display("FAIL eval_t3_%0d busy=%b ack=%b tk=%b want 0 0 %b",
                         i, busy, cond_ack, cond_taken, want[i]);
            end
        end
    endtask

    task automatic test_stall();
        set_flags(4'b0000);
        cond_req = 1; cond_code = 4'b1010;
        tick();
        cond_req = 0;
        alu_req = 1; alu_nzcv = 4'b1000;
        #1;
        n_cmp++;
        if (alu_gnt !== 1) begin
            n_bad++;
            $display("FAIL stall_gnt got %b want 1", alu_gnt);
        end
        tick();
        alu_req = 0;
        #1;
        n_cmp++;
        if (cond_ack !== 0 || busy !== 1) begin
            n_bad++;
            $display("FAIL stall_hold ack=%b busy=%b want 0 1", cond_ack, busy);
        end
        tick();
        n_cmp++;
        if (cond_ack !== 1 || cond_taken !== 0 || nzcv !== 4'b1000) begin
            n_bad++;
            $display("FAIL stall_ack ack=%b tk=%b nzcv=%b want 1 0 1000",
                     cond_ack, cond_taken, nzcv);
        end
        tick();
    endtask

    task automatic test_guard();
        cond_req = 1; cond_code = 4'b1110;
        tick();
        cond_req = 0;
        alu_req = 1;
        for (int k = 1; k <= 5; k++) begin
            alu_nzcv = 4'(k);
            #1;
            n_cmp++;
            if (alu_gnt !== (k != 4) || cond_ack !== (k == 5)) begin
                n_bad++;
                $display("FAIL guard_t%0d gnt=%b ack=%b want %b %b",
                         k, alu_gnt, cond_ack, k != 4, k == 5);
            end
            tick();
        end
        alu_req = 0;
        #1;
        n_cmp++;
        if (cond_taken !== 1 || nzcv !== 4'd5) begin
            n_bad++;
            $display("FAIL guard_end tk=%b nzcv=%h want 1 5", cond_taken, nzcv);
        end
    endtask

    task automatic test_back_to_back();
        cond_req = 1; cond_code = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            tick();
            n_cmp++;
            if (cond_ack !== (k == 1 || k == 4)) begin
                n_bad++;
                $display("FAIL b2b_t%0d ack=%b want %b", k, cond_ack,
                         k == 1 || k == 4);
            end
        end
        cond_req = 0;
        tick();
        tick();
    endtask

    task automatic test_shadow();
        do_reset();
        set_flags(4'b0011);
        save_req = 1; tick(); save_req = 0;
        alu_req = 1; alu_nzcv = 4'b1100; tick(); alu_req = 0;
        restore_req = 1; tick(); restore_req = 0;
        #1;
        n_cmp++;
        if (nzcv !== 4'b0011 || save_err !== 0) begin
            n_bad++;
            $display("FAIL shadow_restore nzcv=%b err=%b want 0011 0", nzcv, save_err);
        end
        restore_req = 1; tick(); restore_req = 0;
        #1;
        n_cmp++;
        if (nzcv !== 4'b0011 || save_err !== 1) begin
            n_bad++;
            $display("FAIL shadow_empty nzcv=%b err=%b want 0011 1", nzcv, save_err);
        end
        do_reset();
        set_flags(4'b0011);
        save_req = 1; tick();
        sys_req = 1; sys_nzcv = 4'b0101; tick();
        save_req = 0; sys_req = 0;
        #1;
        n_cmp++;
        if (save_err !== 1 || nzcv !== 4'b0101) begin
            n_bad++;
            $display("FAIL shadow_dbl err=%b nzcv=%b want 1 0101", save_err, nzcv);
        end
        restore_req = 1; tick(); restore_req = 0;
        #1;
        n_cmp++;
        if (nzcv !== 4'b0011) begin
            n_bad++;
            $display("FAIL shadow_kept nzcv=%b want 0011", nzcv);
        end
    endtask

    task automatic test_save_restore_same();
        do_reset();
        set_flags(4'b1010);
        save_req = 1; tick(); save_req = 0;
        alu_req = 1; alu_nzcv = 4'b0101; tick(); alu_req = 0;
        save_req = 1; restore_req = 1; tick();
        save_req = 0; restore_req = 0;
        #1;
        n_cmp++;
        if (nzcv !== 4'b1010 || save_err !== 0) begin
            n_bad++;
            $display("FAIL same_cycle nzcv=%b err=%b want 1010 0", nzcv, save_err);
        end
        restore_req = 1; tick(); restore_req = 0;
        #1;
        n_cmp++;
        if (save_err !== 1) begin
            n_bad++;
            $display("FAIL same_cycle_cleared err=%b want 1", save_err);
        end
    endtask

    task automatic test_reset_abort();
        do_reset();
        cond_req = 1; cond_code = 4'b1110;
        tick();
        cond_req = 0;
        reset = 1;
        model_reset();
        #1;
        n_cmp++;
        if (busy !== 0 || cond_ack !== 0) begin
            n_bad++;
            $display("FAIL abort_reset busy=%b ack=%b want 0 0", busy, cond_ack);
        end
        tick();
        reset = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (cond_ack !== 0 || busy !== 0) begin
                n_bad++;
                $display("FAIL abort_noack_%0d ack=%b busy=%b want 0 0",
                         k, cond_ack, busy);
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            if (!(alu_req && !e_alu) || k == 0) begin
                alu_req = ($urandom_range(1) == 1);
                alu_nzcv = 4'($urandom);
            end
            if (!(sys_req && !e_sys) || k == 0) begin
                sys_req = ($urandom_range(3) == 0);
                sys_nzcv = 4'($urandom);
            end
            save_req = ($urandom_range(7) == 0);
            restore_req = ($urandom_range(7) == 0);
            cond_req = ($urandom_range(2) == 0);
            cond_code = 4'($urandom);
            #1;
            model_comb();
            n_cmp++;
            if ({alu_gnt, sys_gnt} !== {e_alu, e_sys} ||
                nzcv !== m_nzcv || sreg !== {m_nzcv, 28'b0} ||
                save_err !== m_err || busy !== m_busy ||
                cond_ack !== (m_busy && m_ack_at == cyc) ||
                cond_taken !== m_taken) begin
                n_bad++;
                $display("FAIL rand_%0d gnt=%b%b nzcv=%b err=%b busy=%b ack=%b tk=%b want %b%b %b %b %b %b %b",
                         k, alu_gnt, sys_gnt, nzcv, save_err, busy, cond_ack,
                         cond_taken, e_alu, e_sys, m_nzcv, m_err, m_busy,
                         m_busy && m_ack_at == cyc, m_taken);
            end
            tick();
            if ($urandom_range(15) == 0 && m_sv) begin
                m_err = m_err;
            end
        end
        idle_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_write();
        test_arb();
        test_eval();
        test_stall();
        test_guard();
        test_back_to_back();
        test_shadow();
        test_save_restore_same();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
